// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch unit: data width, reset PC, increment and FSM state encodings.
package pc_fetch_unit_pkg;

    localparam int              DATA_SIZE      = 32;
    localparam logic [31:0]     RESET_PC_DEF   = 32'h0000_0000;
    localparam int              INST_BYTES_DEF = 4;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2,
        FETCH_HALT = 2'd3
    } fetch_state_e;

    // Word-aligns a redirect target by clearing the two byte-offset bits.
    function automatic logic [DATA_SIZE-1:0] align_target(input logic [DATA_SIZE-1:0] addr);
        return addr & ~DATA_SIZE'(3);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-cache request/response bus between the fetch unit (master) and instCache (slave).
interface pc_fetch_unit_if #(
    parameter int DATA_W = 32
);
    logic              icReqValid;
    logic [DATA_W-1:0] icReqAddr;
    logic              icReqReady;
    logic              icRspValid;
    logic [DATA_W-1:0] icRspInst;

    modport master (
        output icReqValid, icReqAddr,
        input  icReqReady, icRspValid, icRspInst
    );

    modport slave (
        input  icReqValid, icReqAddr,
        output icReqReady, icRspValid, icRspInst
    );
endinterface

// File: rtl/pc_fetch_unit_skid.sv
// fetch_skid_buf: one-entry {inst, pc} holding buffer used while IF_ID is stalled.
module fetch_skid_buf
    import pc_fetch_unit_pkg::*;
#(
    parameter int DATA_W = DATA_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              drain,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_inst,
    input  logic [DATA_W-1:0] in_pc,
    output logic              vld,
    output logic [DATA_W-1:0] out_inst,
    output logic [DATA_W-1:0] out_pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     vld <= 1'b0;
        else if (clear) vld <= 1'b0;
        else if (load)  vld <= 1'b1;
        else if (drain) vld <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (load && !clear) begin
            out_inst <= in_inst;
            out_pc   <= in_pc;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch unit: owns the PC, issues single-outstanding instCache fetches, applies branch redirects.
// Build option FETCH_MISALIGN_CHK_EN: misaligned redirect targets set fetchMisalign and halt fetching.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int                DATA_W     = DATA_SIZE,
    parameter logic [DATA_W-1:0] RESET_PC   = DATA_W'(RESET_PC_DEF),
    parameter int                INST_BYTES = INST_BYTES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branchFlag,
    input  logic [DATA_W-1:0] branchAddr,
    pc_fetch_unit_if.master   ic,
    output logic              ifInstValid,
    output logic [DATA_W-1:0] ifInst,
    output logic [DATA_W-1:0] ifPc,
    output logic              ifFlush,
    output logic              fetchMisalign
);

    fetch_state_e      state, state_nxt;
    logic [DATA_W-1:0] pc, req_pc, tgt;
    logic              req_ok, hs, rsp_fire;
    logic              skid_vld, skid_load, skid_drain;
    logic [DATA_W-1:0] skid_inst, skid_pc;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign;
    assign tgt      = branchAddr;
    assign misalign = branchFlag && (branchAddr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        fetchMisalign <= 1'b0;
        else if (misalign) fetchMisalign <= 1'b1;
    end
`else
    assign tgt           = align_target(branchAddr);
    assign fetchMisalign = 1'b0;
`endif

    // A redirect in REQ suppresses the request so the cache never accepts a wrong-path fetch.
    assign req_ok        = rst_n && (state == FETCH_REQ) && !stall && !skid_vld && !branchFlag;
    assign hs            = req_ok && ic.icReqReady;
    assign ic.icReqValid = req_ok;
    assign ic.icReqAddr  = pc;
    assign rsp_fire      = (state == FETCH_WAIT) && ic.icRspValid && !branchFlag;

    assign skid_load  = rsp_fire && (stall ? ifInstValid : skid_vld);
    assign skid_drain = !stall && skid_vld;

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH_REQ:  if (hs) state_nxt = FETCH_WAIT;
            FETCH_WAIT: begin
                if (branchFlag)         state_nxt = ic.icRspValid ? FETCH_REQ : FETCH_DROP;
                else if (ic.icRspValid) state_nxt = FETCH_REQ;
            end
            FETCH_DROP: if (ic.icRspValid) state_nxt = FETCH_REQ;
            default:    state_nxt = state;
        endcase
`ifdef FETCH_MISALIGN_CHK_EN
        if (misalign) state_nxt = FETCH_HALT;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH_REQ;
            pc          <= RESET_PC;
            ifInstValid <= 1'b0;
            ifFlush     <= 1'b0;
        end else begin
            state   <= state_nxt;
            ifFlush <= branchFlag;
            if (branchFlag) pc <= tgt;
            else if (hs)    pc <= pc + DATA_W'(INST_BYTES);
            if (branchFlag)        ifInstValid <= 1'b0;
            else if (!stall)       ifInstValid <= skid_vld || rsp_fire;
            else if (!ifInstValid) ifInstValid <= rsp_fire;
        end
    end

    always_ff @(posedge clk) begin
        if (hs) req_pc <= pc;
    end

    // Skid content is older than any new response, so it drains first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifInst <= '0;
            ifPc   <= '0;
        end else if (!branchFlag) begin
            if (!stall && skid_vld) begin
                ifInst <= skid_inst;
                ifPc   <= skid_pc;
            end else if (rsp_fire && (!stall || !ifInstValid)) begin
                ifInst <= ic.icRspInst;
                ifPc   <= req_pc;
            end
        end
    end

    fetch_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skid_load),
        .drain    (skid_drain),
        .clear    (branchFlag),
        .in_inst  (ic.icRspInst),
        .in_pc    (req_pc),
        .vld      (skid_vld),
        .out_inst (skid_inst),
        .out_pc   (skid_pc)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: instCache model plus an in-order PC-stream reference for delivered instructions.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branchFlag;
    logic [31:0] branchAddr;
    logic        ifInstValid, ifFlush, fetchMisalign;
    logic [31:0] ifInst, ifPc;

    int checks   = 0;
    int failures = 0;

    pc_fetch_unit_if #(.DATA_W(32)) ic ();

    pc_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branchFlag    (branchFlag),
        .branchAddr    (branchAddr),
        .ic            (ic),
        .ifInstValid   (ifInstValid),
        .ifInst        (ifInst),
        .ifPc          (ifPc),
        .ifFlush       (ifFlush),
        .fetchMisalign (fetchMisalign)
    );

    always #5 clk = ~clk;

    // Cache model: at most one pending request, answered after pend_dly idle cycles.
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_dly, min_lat, max_lat;
    // Reference: PC expected for the next instruction consumed by IF_ID.
    logic [31:0] exp_pc;
    bit          prev_br;
    int          ndel;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step(input bit stl, input bit br, input logic [31:0] ba, input bit rdy);
        bit rsp_now, hs;
        stall           = stl;
        branchFlag      = br;
        branchAddr      = ba;
        ic.icReqReady   = rdy;
        rsp_now         = pend && (pend_dly == 0);
        ic.icRspValid   = rsp_now;
        ic.icRspInst    = rsp_now ? mem_word(pend_addr) : $urandom;
        #1;
        check_val("flush", 32'(ifFlush), 32'(prev_br));
        hs = ic.icReqValid && rdy;
        if (hs) check_val("one_outstanding", 32'(pend), 32'd0);
        if (rsp_now)   pend = 1'b0;
        else if (pend) pend_dly--;
        if (hs) begin
            pend      = 1'b1;
            pend_addr = ic.icReqAddr;
            pend_dly  = $urandom_range(min_lat, max_lat);
        end
        if (ifInstValid && !stl && !br) begin
            check_val("del_pc", ifPc, exp_pc);
            check_val("del_inst", ifInst, mem_word(ifPc));
            exp_pc += 32'd4;
            ndel++;
        end
        if (br) exp_pc = ba & 32'hFFFF_FFFC;
        prev_br = br;
        @(negedge clk);
    endtask

    task automatic wait_new_req();
        for (int i = 0; i < 20 && pend; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 20 && !pend; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        check_val("reach_wait", 32'(pend), 32'd1);
    endtask

    task automatic wait_out_vld();
        for (int i = 0; i < 20 && !ifInstValid; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        check_val("reach_vld", 32'(ifInstValid), 32'd1);
    endtask

    initial begin
        stall = 1'b0; branchFlag = 1'b0; branchAddr = '0;
        ic.icReqReady = 1'b0; ic.icRspValid = 1'b0; ic.icRspInst = '0;
        pend = 1'b0; pend_addr = '0; pend_dly = 0; min_lat = 0; max_lat = 0;
        exp_pc = 32'h0; prev_br = 1'b0; ndel = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_req_vld", 32'(ic.icReqValid), 32'd0);
        check_val("rst_if_vld", 32'(ifInstValid), 32'd0);
        check_val("rst_if_inst", ifInst, 32'd0);
        check_val("rst_if_pc", ifPc, 32'd0);
        check_val("rst_flush", 32'(ifFlush), 32'd0);
        check_val("rst_misalign", 32'(fetchMisalign), 32'd0);

        // First fetch after reset release and its latency.
        rst_n = 1'b1;
        ic.icReqReady = 1'b1;
        #1;
        check_val("first_req_vld", 32'(ic.icReqValid), 32'd1);
        check_val("first_req_addr", ic.icReqAddr, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_val("no_early_vld", 32'(ifInstValid), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_val("lat2_vld", 32'(ifInstValid), 32'd1);
        check_val("lat2_pc", ifPc, 32'h0);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
        check_val("seq_count", 32'(ndel >= 3), 32'd1);

        // Redirect while a fetch is outstanding: its response must be dropped.
        min_lat = 2; max_lat = 2;
        wait_new_req();
        step(1'b0, 1'b1, 32'h40, 1'b1);
        check_val("br_wait_vld", 32'(ifInstValid), 32'd0);
        check_val("br_wait_addr", ic.icReqAddr, 32'h40);
        min_lat = 0; max_lat = 0;
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Stall holds the output register, release lets it go.
        wait_out_vld();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            check_val("stall_hold_vld", 32'(ifInstValid), 32'd1);
            check_val("stall_hold_pc", ifPc, exp_pc);
        end
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect and stall in the same cycle.
        wait_out_vld();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h100, 1'b1);
        check_val("br_stall_vld", 32'(ifInstValid), 32'd0);
        check_val("br_stall_addr", ic.icReqAddr, 32'h100);
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);

        // PC wrap through 0xFFFF_FFFC.
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Randomized traffic: stalls, back-to-back redirects, variable ready and latency.
        min_lat = 0; max_lat = 3;
        ndel = 0;
        for (int i = 0; i < 1500; i++) begin
            bit          br;
            logic [31:0] ba;
            br = ($urandom_range(0, 19) == 0);
            ba = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            step($urandom_range(0, 3) == 0, br, ba, $urandom_range(0, 9) < 7);
        end
        check_val("rand_progress", 32'(ndel > 100), 32'd1);

        // Misaligned redirect target.
        min_lat = 0; max_lat = 0;
        step(1'b0, 1'b1, 32'h42, 1'b1);
`ifdef FETCH_MISALIGN_CHK_EN
        check_val("misalign_flag", 32'(fetchMisalign), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            check_val("halt_no_req", 32'(ic.icReqValid), 32'd0);
            check_val("halt_no_vld", 32'(ifInstValid), 32'd0);
        end
`else
        check_val("misalign_flag", 32'(fetchMisalign), 32'd0);
        check_val("misalign_addr", ic.icReqAddr, 32'h40);
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
